// File: rtl/gpu_coord_pkg.sv
// Shared screen-space coordinate definitions for the origin-shift / unshift stages.
// Q10.10 signed coordinates, 640x480 viewport centred on (320,240).
package gpu_coord_pkg;

   localparam int W    = 21;
   localparam int FRAC = 10;

   localparam logic signed [W-1:0] X_OFS = 21'h50000;
   localparam logic signed [W-1:0] Y_OFS = 21'h3C000;
   localparam logic signed [W-1:0] SCR_W = 21'hA0000;
   localparam logic signed [W-1:0] SCR_H = 21'h78000;

   typedef struct packed {
      logic signed [W-1:0] X;
      logic signed [W-1:0] Y;
      logic signed [W-1:0] Z;
   } vtx_t;

   typedef struct packed {
      logic inview;
      logic ovf;
   } vtx_flags_t;

   // One serialized output beat as held in the output register.
   typedef struct packed {
      vtx_t       vtx;
      vtx_flags_t flags;
      logic [1:0] idx;
      logic       last;
   } beat_t;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   // Signed overflow of d = a - b: operands of opposite sign and result sign flipped from a.
   function automatic logic sub_ovf(input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    input logic [W-1:0] d);
      return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
   endfunction

endpackage

// File: rtl/origin_unshift.sv
// Combinational single-vertex unshift: screen-space -> origin-centred, plus
// viewport containment and subtraction overflow flags.
module origin_unshift
   import gpu_coord_pkg::*;
(
   input  vtx_t       vtx_s_i,
   output vtx_t       vtx_o,
   output vtx_flags_t flags_o
);

   logic signed [W-1:0] x_s;
   logic signed [W-1:0] y_s;
   logic signed [W-1:0] x_c;
   logic signed [W-1:0] y_c;
   logic                x_in;
   logic                y_in;

   assign x_s = vtx_s_i.X;
   assign y_s = vtx_s_i.Y;

   // Wraps mod 2^W; overflow is reported, never saturated.
   assign x_c = x_s - X_OFS;
   assign y_c = y_s - Y_OFS;

   assign vtx_o.X = x_c;
   assign vtx_o.Y = y_c;
   assign vtx_o.Z = vtx_s_i.Z;

   assign x_in = !x_s[W-1] && (x_s < SCR_W);
   assign y_in = !y_s[W-1] && (y_s < SCR_H);

   assign flags_o.inview = x_in && y_in;
   assign flags_o.ovf    = sub_ovf(x_s, X_OFS, x_c) || sub_ovf(y_s, Y_OFS, y_c);

endmodule

// File: rtl/origin_unshift_serializer.sv
// Captures a screen-space quad, unshifts all four vertices at once, and streams them
// out one vertex per beat over valid/ready with back-to-back quad acceptance.
module origin_unshift_serializer
   import gpu_coord_pkg::*;
(
   input  logic         clk,
   input  logic         rst,

   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_vtx1_X,
   input  logic [W-1:0] in_vtx1_Y,
   input  logic [W-1:0] in_vtx1_Z,
   input  logic [W-1:0] in_vtx2_X,
   input  logic [W-1:0] in_vtx2_Y,
   input  logic [W-1:0] in_vtx2_Z,
   input  logic [W-1:0] in_vtx3_X,
   input  logic [W-1:0] in_vtx3_Y,
   input  logic [W-1:0] in_vtx3_Z,
   input  logic [W-1:0] in_vtx4_X,
   input  logic [W-1:0] in_vtx4_Y,
   input  logic [W-1:0] in_vtx4_Z,

   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_X,
   output logic [W-1:0] out_Y,
   output logic [W-1:0] out_Z,
   output logic [1:0]   out_idx,
   output logic         out_last,
   output logic         out_inview,
   output logic         out_ovf
);

   vtx_t       in_vtx     [4];
   vtx_t       conv_vtx   [4];
   vtx_flags_t conv_flags [4];

   state_t     state_q,  state_d;
   logic [1:0] idx_q,    idx_d;
   logic [1:0] idx_inc;
   logic       valid_q,  valid_d;
   beat_t      beat_q,   beat_d;
   vtx_t       quad_q   [4];
   vtx_t       quad_d   [4];
   vtx_flags_t qflags_q [4];
   vtx_flags_t qflags_d [4];

   logic       capture;
   logic       fire;

   assign in_vtx[0] = {in_vtx1_X, in_vtx1_Y, in_vtx1_Z};
   assign in_vtx[1] = {in_vtx2_X, in_vtx2_Y, in_vtx2_Z};
   assign in_vtx[2] = {in_vtx3_X, in_vtx3_Y, in_vtx3_Z};
   assign in_vtx[3] = {in_vtx4_X, in_vtx4_Y, in_vtx4_Z};

   for (genvar g = 0; g < 4; g++) begin : g_unshift
      origin_unshift u_unshift (
         .vtx_s_i (in_vtx[g]),
         .vtx_o   (conv_vtx[g]),
         .flags_o (conv_flags[g])
      );
   end

   // Accepting on the last beat's handshake is what keeps quads bubble-free;
   // this makes in_ready combinational from out_ready.
   assign in_ready = !rst &&
                     ((state_q == IDLE) ||
                      ((state_q == SEND) && (idx_q == 2'd3) && out_ready));

   assign capture = in_valid && in_ready;
   assign fire    = valid_q && out_ready;
   assign idx_inc = idx_q + 2'd1;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d  = state_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      beat_d   = beat_q;
      quad_d   = quad_q;
      qflags_d = qflags_q;

      if (capture) begin
         quad_d   = conv_vtx;
         qflags_d = conv_flags;
         state_d  = SEND;
         idx_d    = 2'd0;
         valid_d  = 1'b1;
         beat_d   = '{vtx: conv_vtx[0], flags: conv_flags[0], idx: 2'd0, last: 1'b0};
      end else if (fire) begin
         if (idx_q != 2'd3) begin
            idx_d  = idx_inc;
            beat_d = '{vtx:   quad_q[idx_inc],
                       flags: qflags_q[idx_inc],
                       idx:   idx_inc,
                       last:  (idx_inc == 2'd3)};
         end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         valid_q <= 1'b0;
         beat_q  <= '0;
         // NOTE: quad storage is cleared on reset so a restart can never replay a stale quad.
         for (int i = 0; i < 4; i++) begin
            quad_q[i]   <= '0;
            qflags_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         beat_q   <= beat_d;
         quad_q   <= quad_d;
         qflags_q <= qflags_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_X      = beat_q.vtx.X;
   assign out_Y      = beat_q.vtx.Y;
   assign out_Z      = beat_q.vtx.Z;
   assign out_idx    = beat_q.idx;
   assign out_last   = beat_q.last;
   assign out_inview = beat_q.flags.inview;
   assign out_ovf    = beat_q.flags.ovf;

endmodule

// File: tb/tb_origin_unshift_serializer.sv
// Directed scoreboard bench for origin_unshift_serializer: expected beats are queued
// when a quad is accepted and compared as the DUT emits them.
module tb_origin_unshift_serializer;

   typedef struct {
      logic [62:0] data;   // {X, Y, Z}
      logic [4:0]  meta;   // {idx, last, inview, ovf}
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [20:0] xs [4];
   logic [20:0] ys [4];
   logic [20:0] zs [4];
   logic        out_valid;
   logic        out_ready;
   logic [20:0] out_X;
   logic [20:0] out_Y;
   logic [20:0] out_Z;
   logic [1:0]  out_idx;
   logic        out_last;
   logic        out_inview;
   logic        out_ovf;

   int   errors;
   int   checks;
   logic accepted;
   exp_t sb [$];

   origin_unshift_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_vtx1_X  (xs[0]), .in_vtx1_Y (ys[0]), .in_vtx1_Z (zs[0]),
      .in_vtx2_X  (xs[1]), .in_vtx2_Y (ys[1]), .in_vtx2_Z (zs[1]),
      .in_vtx3_X  (xs[2]), .in_vtx3_Y (ys[2]), .in_vtx3_Z (zs[2]),
      .in_vtx4_X  (xs[3]), .in_vtx4_Y (ys[3]), .in_vtx4_Z (zs[3]),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_X      (out_X),
      .out_Y      (out_Y),
      .out_Z      (out_Z),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .out_inview (out_inview),
      .out_ovf    (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model using wide integer arithmetic on real coordinate values.
   function automatic exp_t model(input logic [20:0] xv, input logic [20:0] yv,
                                  input logic [20:0] zv, input int v);
      int   sx, sy, dx, dy;
      logic ox, oy, iv;
      exp_t r;
      sx = int'($signed(xv));
      sy = int'($signed(yv));
      dx = sx - 320 * 1024;
      dy = sy - 240 * 1024;
      ox = (dx < -(1 << 20)) || (dx > (1 << 20) - 1);
      oy = (dy < -(1 << 20)) || (dy > (1 << 20) - 1);
      iv = (sx >= 0) && (sx < 640 * 1024) && (sy >= 0) && (sy < 480 * 1024);
      r.data = {dx[20:0], dy[20:0], zv};
      r.meta = {2'(v), (v == 3), iv, (ox || oy)};
      return r;
   endfunction

   task automatic push_quad();
      for (int v = 0; v < 4; v++) sb.push_back(model(xs[v], ys[v], zs[v], v));
   endtask

   // One clock: score any beat and any quad handshake at the falling edge, then step
   // to just after the rising edge where inputs are changed.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_data", {1'b0, out_X, out_Y, out_Z}, {1'b0, e.data});
            check("beat_meta", 64'({out_idx, out_last, out_inview, out_ovf}), 64'(e.meta));
         end
      end
      if (in_valid && in_ready) begin
         push_quad();
         accepted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_quad(input logic keep_valid);
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) tick();
      check("quad_accepted", 64'(accepted), 64'd1);
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("drain_empty", 64'(sb.size()), 64'd0);
      check("drain_idle", 64'(out_valid), 64'd0);
   endtask

   task automatic set_vtx(input int v, input logic [20:0] x, input logic [20:0] y,
                          input logic [20:0] z);
      xs[v] = x;
      ys[v] = y;
      zs[v] = z;
   endtask

   initial begin
      exp_t hold;
      errors    = 0;
      checks    = 0;
      accepted  = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int v = 0; v < 4; v++) set_vtx(v, 21'h0, 21'h0, 21'h0);

      // Reset state
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_xyz", {1'b0, out_X, out_Y, out_Z}, 64'd0);
      check("rst_out_meta", 64'({out_idx, out_last, out_inview, out_ovf}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // 1: basic quad, 4 consecutive beats, last only on beat 3
      set_vtx(0, 21'h50000, 21'h3C000, 21'h01234);
      for (int v = 1; v < 4; v++) set_vtx(v, 21'h50400, 21'h3C400, 21'h0);
      out_ready = 1'b1;
      send_quad(1'b0);
      check("t1_latency_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("t1_consecutive_valid", 64'(out_valid), 64'd1);
         tick();
      end
      check("t1_done_valid", 64'(out_valid), 64'd0);
      check("t1_sb_empty", 64'(sb.size()), 64'd0);

      // 2: origin corner and viewport edges
      out_ready = 1'b0;
      set_vtx(0, 21'h00000, 21'h00000, 21'h00000);
      set_vtx(1, 21'hA0000, 21'h00000, 21'h00007);
      set_vtx(2, 21'h00000, 21'h1FFFFF, 21'h1FFFFF);
      set_vtx(3, 21'h9FC00, 21'h77C00, 21'h00100);
      send_quad(1'b0);
      check("t2_corner_x", 64'(out_X), 64'h1B0000);
      check("t2_corner_y", 64'(out_Y), 64'h1C4000);
      check("t2_corner_inview", 64'(out_inview), 64'd1);
      check("t2_corner_ovf", 64'(out_ovf), 64'd0);
      out_ready = 1'b1;
      drain();

      // 3: subtraction overflow wraps and flags
      out_ready = 1'b0;
      set_vtx(0, 21'h100000, 21'h3C000, 21'h00001);
      set_vtx(1, 21'h0FFFFF, 21'h100000, 21'h00002);
      set_vtx(2, 21'h1B0000, 21'h00000, 21'h00003);
      set_vtx(3, 21'h50000, 21'h0FFFFF, 21'h00004);
      send_quad(1'b0);
      check("t3_min_x_wrap", 64'(out_X), 64'h0B0000);
      check("t3_min_x_ovf", 64'(out_ovf), 64'd1);
      out_ready = 1'b1;
      drain();

      // 4: backpressure at idx 1 holds outputs and blocks new input
      set_vtx(0, 21'h10000, 21'h11000, 21'h00011);
      set_vtx(1, 21'h20000, 21'h22000, 21'h00022);
      set_vtx(2, 21'h30000, 21'h33000, 21'h00033);
      set_vtx(3, 21'h40000, 21'h44000, 21'h00044);
      out_ready = 1'b1;
      send_quad(1'b0);
      tick();
      out_ready = 1'b0;
      hold = sb[0];
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         for (int v = 0; v < 4; v++) set_vtx(v, xs[v] ^ 21'h1555, ys[v] ^ 21'h0AAA, zs[v] + 21'h1);
         check("t4_stall_data", {1'b0, out_X, out_Y, out_Z}, {1'b0, hold.data});
         check("t4_stall_meta", 64'({out_idx, out_last, out_inview, out_ovf}), 64'(hold.meta));
         check("t4_stall_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // 5: two quads back-to-back, 8 beats in 8 cycles
      set_vtx(0, 21'h00400, 21'h00800, 21'h00001);
      set_vtx(1, 21'h60000, 21'h50000, 21'h00002);
      set_vtx(2, 21'h1FFC00, 21'h3C000, 21'h00003);
      set_vtx(3, 21'h50000, 21'h78000, 21'h00004);
      out_ready = 1'b1;
      send_quad(1'b1);
      set_vtx(0, 21'h7FC00, 21'h10000, 21'h00005);
      set_vtx(1, 21'h0FFFFF, 21'h1FFFFF, 21'h00006);
      set_vtx(2, 21'h50400, 21'h3BC00, 21'h00007);
      set_vtx(3, 21'h00000, 21'h77FFF, 21'h00008);
      for (int i = 0; i < 8; i++) begin
         check("t5_beat_valid", 64'(out_valid), 64'd1);
         check("t5_in_ready", 64'(in_ready), 64'((i == 3) || (i == 7)));
         tick();
         if (i == 3) in_valid = 1'b0;
      end
      check("t5_done_valid", 64'(out_valid), 64'd0);
      check("t5_sb_empty", 64'(sb.size()), 64'd0);

      // 6: reset mid-quad discards the remainder
      set_vtx(0, 21'h11111, 21'h22222, 21'h33333);
      set_vtx(1, 21'h44444, 21'h55555, 21'h66666);
      set_vtx(2, 21'h77777, 21'h08888, 21'h09999);
      set_vtx(3, 21'h0AAAA, 21'h0BBBB, 21'h0CCCC);
      out_ready = 1'b1;
      send_quad(1'b0);
      tick();
      tick();
      check("t6_pre_rst_idx", 64'(out_idx), 64'd2);
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", 64'(out_valid), 64'd0);
      check("t6_rst_in_ready", 64'(in_ready), 64'd0);
      check("t6_rst_out_xyz", {1'b0, out_X, out_Y, out_Z}, 64'd0);
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("t6_post_rst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6_no_stale_beat", 64'(out_valid), 64'd0);
      end
      set_vtx(0, 21'h50000, 21'h3C000, 21'h00abc);
      send_quad(1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
